// File: rtl/arith_acc_ctrl.sv
// rtl/arith_acc_ctrl.sv - command-driven accumulator controller in front of arithmetic_unit
module arith_acc_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic [1:0]       au_sel,
    input  logic [WIDTH-1:0] au_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] acc,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic       accept;
    logic       rsp_done;

    assign accept    = cmd_valid & cmd_ready;
    assign rsp_done  = rsp_valid & rsp_ready;
    assign flag_zero = (acc == '0);
    assign flag_neg  = acc[WIDTH-1];

    // State register; reset anywhere aborts the op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; cmd_ready is held low while reset is asserted.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture on accept: arithmetic_unit inputs then stay frozen through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_LOAD;
            au_a   <= '0;
            au_b   <= '0;
            au_sel <= 2'b00;
        end else if (accept) begin
            op_q <= cmd_op;
            au_a <= acc;
            au_b <= cmd_operand;
            case (cmd_op)
                OP_ADD:  au_sel <= 2'b00;
                OP_INC:  au_sel <= 2'b01;
                OP_SUB:  au_sel <= 2'b10;
                OP_DEC:  au_sel <= 2'b11;
                default: au_sel <= au_sel;
            endcase
        end
    end

    // Accumulator and error update in the single EXEC cycle; au_b doubles as the LOAD value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            rsp_err <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_err <= 1'b0;
            case (op_q)
                OP_ADD, OP_INC, OP_SUB, OP_DEC: acc <= au_result;
                OP_LOAD:                        acc <= au_b;
                OP_CLR:                         acc <= '0;
                default:                        rsp_err <= 1'b1;
            endcase
        end
    end

    // Completed-response counter, wraps naturally; illegal ops count too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_done) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_arith_acc_ctrl.sv
// tb/tb_arith_acc_ctrl.sv - scoreboard testbench for arith_acc_ctrl
module tb_arith_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_operand = 8'd0;
    logic [7:0] au_a;
    logic [7:0] au_b;
    logic [1:0] au_sel;
    logic [7:0] au_result;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] acc;
    logic       flag_zero;
    logic       flag_neg;
    logic       rsp_err;
    logic [7:0] op_count;

    int tests = 0;
    int fails = 0;
    bit bp_hold = 1'b0;

    typedef struct {
        logic [7:0] acc;
        logic       err;
        logic [1:0] sel;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] m_acc = 8'd0;
    logic [1:0] m_sel = 2'b00;
    logic [7:0] m_cnt = 8'd0;

    arith_acc_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_operand(cmd_operand),
        .au_a(au_a),
        .au_b(au_b),
        .au_sel(au_sel),
        .au_result(au_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .acc(acc),
        .flag_zero(flag_zero),
        .flag_neg(flag_neg),
        .rsp_err(rsp_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        au_result = 8'd0;
        case (au_sel)
            2'b00: au_result = au_a + au_b;
            2'b01: au_result = au_a + 8'd1;
            2'b10: au_result = au_a - au_b;
            default: au_result = au_a - 8'd1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model_step(input logic [2:0] op, input logic [7:0] opnd);
        exp_t e;
        int   a;
        a = int'(m_acc);
        e.err = 1'b0;
        case (op)
            3'd0: a = int'(opnd);
            3'd1: begin a = a + int'(opnd); m_sel = 2'b00; end
            3'd2: begin a = a + 1;          m_sel = 2'b01; end
            3'd3: begin a = a - int'(opnd); m_sel = 2'b10; end
            3'd4: begin a = a - 1;          m_sel = 2'b11; end
            3'd5: a = 0;
            default: e.err = 1'b1;
        endcase
        m_acc = 8'(a % 256 + 256);
        e.acc = m_acc;
        e.sel = m_sel;
        e.cnt = m_cnt;
        m_cnt = m_cnt + 8'd1;
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [7:0] opnd, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_ready_timeout", 32'd0, 32'd1);
            return;
        end
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = opnd;
        if (push) exp_q.push_back(model_step(op, opnd));
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'($urandom);
        cmd_operand = 8'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            exp_q.delete();
            return;
        end
        @(negedge clk);
        chk("op_count_after", 32'(op_count), 32'(m_cnt));
        chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [7:0] opnd);
        issue(op, opnd, 1'b1);
        wait_done();
    endtask

    // Response monitor: pops one expectation per completed response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_acc", 32'(acc), 32'(e.acc));
                chk("rsp_zero", 32'(flag_zero), 32'(e.acc == 8'd0));
                chk("rsp_neg", 32'(flag_neg), 32'(e.acc[7]));
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_sel", 32'(au_sel), 32'(e.sel));
                chk("rsp_count", 32'(op_count), 32'(e.cnt));
                chk("rsp_no_cmd_ready", 32'(cmd_ready), 32'd0);
            end
        end
    end

    // Response consumer with random backpressure, or held off entirely on request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_au_sel", 32'(au_sel), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        do_cmd(3'd0, 8'h02);
        do_cmd(3'd1, 8'h03);
        do_cmd(3'd2, 8'h00);
        do_cmd(3'd3, 8'h07);
        do_cmd(3'd4, 8'h00);
        do_cmd(3'd0, 8'hFF);
        do_cmd(3'd1, 8'h01);
        do_cmd(3'd5, 8'h00);
        do_cmd(3'd4, 8'h00);

        bp_hold = 1'b1;
        issue(3'd2, 8'h00, 1'b1);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
        chk("bp_rsp_valid_seen", 32'(rsp_valid), 32'd1);
        cmd_op      = 3'd0;
        cmd_operand = 8'h55;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_acc", 32'(acc), 32'(m_acc));
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_count", 32'(op_count), 32'(m_cnt - 8'd1));
        end
        cmd_valid = 1'b0;
        bp_hold   = 1'b0;
        wait_done();

        do_cmd(3'd0, 8'h06);
        do_cmd(3'd6, 8'h33);
        do_cmd(3'd7, 8'h44);
        do_cmd(3'd2, 8'h00);

        do_cmd(3'd0, 8'h10);
        issue(3'd1, 8'h01, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_acc", 32'(acc), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_op_count", 32'(op_count), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        m_acc = 8'd0;
        m_sel = 2'b00;
        m_cnt = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 300; i++) begin
            do_cmd(3'($urandom_range(0, 7)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
